// File: rtl/mul_pkg.sv
// Shared MUL encodings, instruction field positions and controller types.
// Imported by the issue controller, its hold buffer, ucode and the decoder.
package mul_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TYPE_W  = 2;

  localparam int unsigned OPC_LSB  = 25;
  localparam int unsigned DEST_LSB = 21;
  localparam int unsigned SRC_LSB  = 17;
  localparam int unsigned RS2_LSB  = 13;
  localparam int unsigned IMM_LSB  = 0;

  localparam logic [OPC_W-1:0] OPC_MULI  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_MULR  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_MULSI = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_MULSR = 7'b0111011;

  localparam logic [INSTR_W-1:0] NOP_INSTR = {5'b11001, 27'b0};

  localparam logic [TYPE_W-1:0] MT_MULI  = 2'd0;
  localparam logic [TYPE_W-1:0] MT_MULR  = 2'd1;
  localparam logic [TYPE_W-1:0] MT_MULSI = 2'd2;
  localparam logic [TYPE_W-1:0] MT_MULSR = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    BUSY   = 2'd2,
    REPLAY = 2'd3
  } mul_state_e;

  // Operand bundle handed to the ucode MUL sequencer.
  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  src;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] rdata2;
    logic [TYPE_W-1:0] mtype;
  } mul_op_t;

  function automatic logic is_mul_opc(input logic [OPC_W-1:0] opc);
    return (opc == OPC_MULI) || (opc == OPC_MULR) ||
           (opc == OPC_MULSI) || (opc == OPC_MULSR);
  endfunction

  function automatic logic [TYPE_W-1:0] mul_type_of(input logic [OPC_W-1:0] opc);
    logic [TYPE_W-1:0] t;
    case (opc)
      OPC_MULR:  t = MT_MULR;
      OPC_MULSI: t = MT_MULSI;
      OPC_MULSR: t = MT_MULSR;
      default:   t = MT_MULI;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mul_hold_buf.sv
// One-entry skid register holding the instruction fetched behind a MUL.
module mul_hold_buf
  import mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture,
  input  logic               clear,
  input  logic [INSTR_W-1:0] din,
  output logic [INSTR_W-1:0] dout,
  output logic               valid
);

  logic [INSTR_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Detects MUL opcodes between IF/ID and the ucode MUL sequencer: issues start_mul,
// stalls fetch, forwards sequencer instructions and replays the instruction behind the MUL.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               if_valid,
  output logic [REG_W-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata2,
  input  logic [INSTR_W-1:0] uc_instr,
  input  logic               uc_mux_ctrl,
  input  logic               uc_mul_release,
  output logic               start_mul,
  output logic [REG_W-1:0]   mul_dest,
  output logic [REG_W-1:0]   mul_src,
  output logic [IMM_W-1:0]   mul_imm,
  output logic [DATA_W-1:0]  mul_rdata2,
  output logic [TYPE_W-1:0]  mul_type,
  output logic               fetch_stall,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid,
  output logic               mul_error
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mul_state_e         state_q, state_d;
  mul_op_t            op_q, op_d, cap_op;
  logic               start_mul_q, start_mul_d;
  logic               fetch_stall_q, fetch_stall_d;
  logic               mul_error_q, mul_error_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               rel_q, rel_d;

  logic [INSTR_W-1:0] hold_instr;
  logic               hold_valid, hold_cap, hold_clr;
  logic [INSTR_W-1:0] cap_instr;
  logic [OPC_W-1:0]   cap_opc;
  logic               rel_edge, wd_expired;
  logic [INSTR_W-1:0] id_instr_c;
  logic               id_valid_c;

  mul_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst),
    .capture (hold_cap),
    .clear   (hold_clr),
    .din     (if_instr),
    .dout    (hold_instr),
    .valid   (hold_valid)
  );

  // In REPLAY the buffered instruction is the decode candidate; otherwise the fetched one.
  assign cap_instr = (state_q == REPLAY) ? hold_instr : if_instr;
  assign cap_opc   = cap_instr[OPC_LSB +: OPC_W];
  assign rf_raddr2 = cap_instr[RS2_LSB +: REG_W];

  always_comb begin
    cap_op.dest   = cap_instr[DEST_LSB +: REG_W];
    cap_op.src    = cap_instr[SRC_LSB +: REG_W];
    cap_op.imm    = cap_instr[IMM_LSB +: IMM_W];
    cap_op.rdata2 = rf_rdata2;
    cap_op.mtype  = mul_type_of(cap_opc);
  end

  // A release level left high from an earlier MUL must not count, so act on edges only.
  assign rel_d      = uc_mul_release;
  assign rel_edge   = uc_mul_release & ~rel_q;
  assign wd_expired = (wdog_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    start_mul_d   = 1'b0;
    fetch_stall_d = fetch_stall_q;
    mul_error_d   = mul_error_q;
    wdog_d        = wdog_q;
    hold_cap      = 1'b0;
    hold_clr      = 1'b0;
    id_instr_c    = NOP_INSTR;
    id_valid_c    = 1'b0;

    case (state_q)
      IDLE: begin
        id_instr_c = if_instr;
        id_valid_c = if_valid;
        if (if_valid && is_mul_opc(cap_opc)) begin
          op_d          = cap_op;
          start_mul_d   = 1'b1;
          fetch_stall_d = 1'b1;
          id_instr_c    = NOP_INSTR;
          id_valid_c    = 1'b0;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        hold_cap = if_valid;
        wdog_d   = '0;
        state_d  = BUSY;
      end

      BUSY: begin
        if (uc_mux_ctrl) begin
          id_instr_c = uc_instr;
          id_valid_c = 1'b1;
        end
        wdog_d = wdog_q + CNT_W'(1);
        // A release in the same cycle as expiry is a normal completion.
        if (rel_edge || wd_expired) begin
          if (!rel_edge) begin
            mul_error_d = 1'b1;
          end
          if (hold_valid) begin
            state_d = REPLAY;
          end else begin
            fetch_stall_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end

      REPLAY: begin
        hold_clr = 1'b1;
        if (is_mul_opc(cap_opc)) begin
          op_d        = cap_op;
          start_mul_d = 1'b1;
          state_d     = ISSUE;
        end else begin
          id_instr_c    = hold_instr;
          id_valid_c    = 1'b1;
          fetch_stall_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      start_mul_q   <= 1'b0;
      fetch_stall_q <= 1'b0;
      mul_error_q   <= 1'b0;
      wdog_q        <= '0;
      rel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      start_mul_q   <= start_mul_d;
      fetch_stall_q <= fetch_stall_d;
      mul_error_q   <= mul_error_d;
      wdog_q        <= wdog_d;
      rel_q         <= rel_d;
    end
  end

  assign start_mul   = start_mul_q;
  assign mul_dest    = op_q.dest;
  assign mul_src     = op_q.src;
  assign mul_imm     = op_q.imm;
  assign mul_rdata2  = op_q.rdata2;
  assign mul_type    = op_q.mtype;
  assign fetch_stall = fetch_stall_q;
  assign mul_error   = mul_error_q;

  // Decode side sees a NOP bubble for as long as reset is held.
  assign id_instr = rst ? id_instr_c : NOP_INSTR;
  assign id_valid = rst & id_valid_c;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed MUL transactions plus randomized ones,
// with expectations derived per transaction from the opcode/operand/release rules.
module tb_mul_issue_ctrl;

  localparam int unsigned TO = 16;
  localparam logic [31:0] NOP = 32'hC800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [3:0]  rf_raddr2;
  logic [31:0] rf_rdata2;
  logic [31:0] uc_instr;
  logic        uc_mux_ctrl;
  logic        uc_mul_release;
  logic        start_mul;
  logic [3:0]  mul_dest;
  logic [3:0]  mul_src;
  logic [15:0] mul_imm;
  logic [31:0] mul_rdata2;
  logic [1:0]  mul_type;
  logic        fetch_stall;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        mul_error;

  logic [31:0] rf_mem [16];
  logic [6:0]  opc_tab [4];
  int          total = 0;
  int          bad   = 0;
  bit          err_exp = 1'b0;

  always #5 clk = ~clk;

  // Register file model: same-cycle read.
  always_comb rf_rdata2 = rf_mem[rf_raddr2];

  mul_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid),
    .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2), .uc_instr(uc_instr),
    .uc_mux_ctrl(uc_mux_ctrl), .uc_mul_release(uc_mul_release),
    .start_mul(start_mul), .mul_dest(mul_dest), .mul_src(mul_src),
    .mul_imm(mul_imm), .mul_rdata2(mul_rdata2), .mul_type(mul_type),
    .fetch_stall(fetch_stall), .id_instr(id_instr), .id_valid(id_valid),
    .mul_error(mul_error)
  );

  function automatic int kind_of(input logic [31:0] i);
    for (int k = 0; k < 4; k++) if (i[31:25] == opc_tab[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] rand_mul(input int k);
    logic [31:0] r;
    r = $urandom;
    r[31:25] = opc_tab[k];
    return r;
  endfunction

  function automatic logic [31:0] rand_other();
    logic [31:0] r;
    r = $urandom;
    while (kind_of(r) >= 0) r = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_id_instr"}, id_instr, NOP);
    chk({tag, "_id_valid"}, 32'(id_valid), 0);
    chk({tag, "_start"}, 32'(start_mul), 0);
    chk({tag, "_stall"}, 32'(fetch_stall), 0);
    chk({tag, "_err"}, 32'(mul_error), 0);
    chk({tag, "_dest"}, 32'(mul_dest), 0);
    chk({tag, "_src"}, 32'(mul_src), 0);
    chk({tag, "_imm"}, 32'(mul_imm), 0);
    chk({tag, "_rdata2"}, mul_rdata2, 0);
    chk({tag, "_type"}, 32'(mul_type), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      if_valid    = 1'($urandom_range(0, 1));
      if_instr    = if_valid ? rand_other() : rand_mul(int'($urandom_range(0, 3)));
      uc_mux_ctrl = 1'($urandom_range(0, 1));
      uc_instr    = $urandom;
      @(negedge clk);
      chk("idle_valid", 32'(id_valid), 32'(if_valid));
      if (if_valid) chk("idle_instr", id_instr, if_instr);
      chk("idle_stall", 32'(fetch_stall), 0);
      chk("idle_start", 32'(start_mul), 0);
      chk("idle_err", 32'(mul_error), 32'(err_exp));
      nxt();
    end
  endtask

  // One MUL from detection to return to IDLE; a MUL follower is chained through replay.
  task automatic mul_txn(input logic [31:0] mul, input bit has_f, input logic [31:0] f,
                         input int rel_at, input bit pre_high, input int rel2);
    logic [31:0] cur;
    bit hf, from_replay, pre, timed;
    int rel, end_k;
    cur = mul; hf = has_f; from_replay = 1'b0; rel = rel_at; pre = pre_high;
    for (int pass = 0; pass < 2; pass++) begin
      uc_mul_release = pre;
      uc_mux_ctrl    = 1'($urandom_range(0, 1));
      uc_instr       = $urandom;
      if (!from_replay) begin
        if_valid = 1'b1;
        if_instr = cur;
      end else begin
        if_valid = 1'($urandom_range(0, 1));
        if_instr = rand_other();
        if_instr[16:13] = ~cur[16:13];
      end
      @(negedge clk);
      chk("entry_id_valid", 32'(id_valid), 0);
      chk("entry_raddr2", 32'(rf_raddr2), 32'(cur[16:13]));
      chk("entry_stall", 32'(fetch_stall), 32'(from_replay));
      chk("entry_start", 32'(start_mul), 0);
      nxt();

      if_valid    = hf;
      if_instr    = hf ? f : rand_other();
      uc_mux_ctrl = 1'($urandom_range(0, 1));
      uc_instr    = $urandom;
      @(negedge clk);
      chk("issue_start", 32'(start_mul), 1);
      chk("issue_id_valid", 32'(id_valid), 0);
      chk("issue_stall", 32'(fetch_stall), 1);
      chk("issue_dest", 32'(mul_dest), 32'(cur[24:21]));
      chk("issue_src", 32'(mul_src), 32'(cur[20:17]));
      chk("issue_imm", 32'(mul_imm), 32'(cur[15:0]));
      chk("issue_type", 32'(mul_type), 32'(kind_of(cur)));
      chk("issue_rdata2", mul_rdata2, rf_mem[cur[16:13]]);
      chk("issue_err", 32'(mul_error), 32'(err_exp));
      nxt();

      timed = !(rel >= 1 && rel <= int'(TO));
      end_k = timed ? int'(TO) : rel;
      for (int k = 1; k <= end_k; k++) begin
        uc_mul_release = (k == rel) || (pre && (rel == 0 || k < rel - 1));
        uc_mux_ctrl    = 1'($urandom_range(0, 1));
        uc_instr       = $urandom;
        if_valid       = 1'($urandom_range(0, 1));
        if_instr       = $urandom;
        @(negedge clk);
        chk("busy_valid", 32'(id_valid), 32'(uc_mux_ctrl));
        if (uc_mux_ctrl) chk("busy_instr", id_instr, uc_instr);
        chk("busy_stall", 32'(fetch_stall), 1);
        chk("busy_start", 32'(start_mul), 0);
        chk("busy_err", 32'(mul_error), 32'(err_exp));
        nxt();
      end
      if (timed) err_exp = 1'b1;

      if (hf && kind_of(f) >= 0) begin
        cur = f; hf = 1'b0; from_replay = 1'b1; rel = rel2; pre = 1'b1;
        continue;
      end
      if (hf) begin
        if_valid    = 1'($urandom_range(0, 1));
        if_instr    = rand_other();
        uc_mux_ctrl = 1'b1;
        uc_instr    = $urandom;
        @(negedge clk);
        chk("replay_valid", 32'(id_valid), 1);
        chk("replay_instr", id_instr, f);
        chk("replay_stall", 32'(fetch_stall), 1);
        chk("replay_start", 32'(start_mul), 0);
        chk("replay_err", 32'(mul_error), 32'(err_exp));
        nxt();
      end
      if_valid    = 1'b0;
      if_instr    = rand_other();
      uc_mux_ctrl = 1'b0;
      @(negedge clk);
      chk("done_stall", 32'(fetch_stall), 0);
      chk("done_valid", 32'(id_valid), 0);
      chk("done_start", 32'(start_mul), 0);
      chk("done_err", 32'(mul_error), 32'(err_exp));
      nxt();
      break;
    end
  endtask

  initial begin
    logic [31:0] m, fo;
    bit hf, pre;
    int rel, rel2;
    opc_tab[0] = 7'b0010011;
    opc_tab[1] = 7'b0110011;
    opc_tab[2] = 7'b0011011;
    opc_tab[3] = 7'b0111011;
    for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
    rf_mem[5] = 32'hFFFF_FFFE;

    rst = 1'b0;
    if_valid = 1'b1;
    if_instr = rand_mul(0);
    uc_instr = $urandom;
    uc_mux_ctrl = 1'b1;
    uc_mul_release = 1'b0;
    #12;
    chk_reset("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles(4);

    // MULI R1,R0,#3 followed by a non-MUL
    mul_txn({7'b0010011, 4'd1, 4'd0, 17'd3}, 1'b1, rand_other(), 3, 1'b0, 0);
    // MULR reading R5 = FFFF_FFFE
    mul_txn({7'b0110011, 4'd7, 4'd2, 17'h0A000}, 1'b0, 32'h0, 2, 1'b0, 0);
    idle_cycles(2);
    // MULSI then MULSR back to back, second issued from replay
    mul_txn(rand_mul(2), 1'b1, {7'b0111011, 4'd3, 4'd4, 17'h0A000}, 4, 1'b0, 5);
    // release level held high from before the MUL
    mul_txn(rand_mul(1), 1'b1, rand_other(), 6, 1'b1, 0);
    // release coincides with watchdog expiry
    mul_txn(rand_mul(0), 1'b1, rand_other(), int'(TO), 1'b0, 0);
    // no release: watchdog abort, then sticky error across a later MUL
    mul_txn(rand_mul(3), 1'b1, rand_other(), 0, 1'b0, 0);
    mul_txn(rand_mul(1), 1'b0, 32'h0, 2, 1'b0, 0);

    // asynchronous reset while BUSY with a held instruction
    if_valid = 1'b1; if_instr = rand_mul(1); uc_mul_release = 1'b0; uc_mux_ctrl = 1'b0;
    nxt();
    if_valid = 1'b1; if_instr = rand_other();
    nxt();
    for (int c = 0; c < 3; c++) begin
      if_valid = 1'b0; uc_mux_ctrl = 1'b1; uc_instr = $urandom;
      @(negedge clk);
      chk("prerst_busy_valid", 32'(id_valid), 1);
      nxt();
    end
    #2 rst = 1'b0;
    #1 chk_reset("rst_mid");
    err_exp = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    uc_mux_ctrl = 1'b0;
    idle_cycles(2);
    mul_txn(rand_mul(0), 1'b1, rand_other(), 2, 1'b0, 0);

    for (int t = 0; t < 25; t++) begin
      m   = rand_mul(int'($urandom_range(0, 3)));
      hf  = 1'($urandom_range(0, 1));
      fo  = ($urandom_range(0, 2) == 0) ? rand_mul(int'($urandom_range(0, 3))) : rand_other();
      pre = 1'($urandom_range(0, 1));
      rel = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(pre ? 3 : 1, TO));
      rel2 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(3, TO));
      mul_txn(m, hf, fo, rel, pre, rel2);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
